q2_rr_arbiter4: RTL and testbench
=================================

Name: q2_rr_arbiter4

Overview:
Round-robin arbiter that shares one 4:1 mux datapath among four requesters. It registers a one-hot grant and the matching 2-bit mux select, and holds the grant while the owner keeps its request. On release it rotates to the next pending requester with no idle bubble. It sits beside q1_mux4to1: sel drives the mux s input and grant[i] enables requester i.

Parameters:
MAX_HOLD, 8, cycles an owner may hold the grant before preemption (used only with ARB_HOLD_LIMIT_EN); legal range 2..255.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request vector; req[i]=1 means requester i wants the mux
grant  output  4  one-hot or zero; grant[i]=1 means requester i owns the mux
sel  output  2  binary index of the current or most recent owner; drives the mux select
busy  output  1  high when any grant is active (|grant)
hold_cnt  output  8  cycles the current owner has held the grant; saturating

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high, and has priority over all other logic, including mid-grant.
- Reset values: grant=0, sel=0, busy=0, hold_cnt=0, state=IDLE, last_ptr=3 (requester 0 has top priority after reset).
- All outputs are registered.
- Latency: a request sampled at edge k produces the grant after edge k, i.e. one-cycle latency.
- Priority order: search starts at (last_ptr+1) mod 4 and wraps through 3→0. First set bit wins.
- IDLE state:
  - If req==0, remain in IDLE; grant=0 and sel holds its previous value.
  - If any req bit is set, grant the winner, set sel=winner and hold_cnt=0, go to GRANT.
- GRANT state, owner o:
  - req[o]=1: stay in GRANT; hold_cnt increments, saturating at 255.
  - req[o]=0, others pending: last_ptr=o; grant the next winner (searching from o+1, excluding o) on the same edge; hold_cnt=0; stay in GRANT. No zero-grant cycle between owners.
  - req[o]=0, none pending: last_ptr=o, grant=0, hold_cnt=0, go to IDLE; sel keeps o.
- Requests from non-owners never disturb the current owner, except through the optional preemption below.
- A request that pulses for a single cycle while another requester owns the mux is not remembered; requesters must hold req until they are granted.
- Only one bit of grant is ever set. Assertion: $onehot0(grant) every cycle.
- sel always equals the index of the set grant bit whenever busy=1.
- All four requesting continuously, with each owner releasing after one cycle of ownership: grant order 0,1,2,3,0,…

Optional Feature:
ARB_HOLD_LIMIT_EN
- Defined: when hold_cnt==MAX_HOLD-1 and any other req bit is set, the next edge preempts the owner even though req[o]=1.
  - last_ptr=o; the next winner is granted; hold_cnt=0.
  - The preempted requester re-enters normal rotation.
  - If no other req bit is set, the owner keeps the grant and hold_cnt keeps counting (saturating).
- Undefined: no preemption; an owner holds indefinitely while req[o]=1, and MAX_HOLD is unused.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=4'b1111 → grant=0, sel=0, busy=0, hold_cnt=0. Release rst → after the next edge, grant=4'b0001, sel=0.
2. Single requester: req=4'b0100 for 5 cycles, then 0 → grant=4'b0100 and sel=2 one edge after req rises; hold_cnt reaches 4. After req falls, grant=0, sel stays 2, busy=0.
3. Rotation: req=4'b1111, each owner drops its req for one cycle after 1 granted cycle, then re-raises → grant sequence 0001, 0010, 0100, 1000, 0001 with no zero-grant cycle.
4. Wrap and priority: last owner 3 released, then req=4'b1010 → grant=4'b0010 (index 1 beats index 3 because search starts at 0).
5. Mid-grant reset: owner 2 holding with hold_cnt=5; assert rst for one cycle → next edge grant=0, hold_cnt=0. First grant afterwards goes to the lowest-index requester.
6. ARB_HOLD_LIMIT_EN with MAX_HOLD=4:
   - req=4'b0011 held constantly → owner 0 for 4 cycles, then grant=4'b0010 for 4 cycles, then back to 4'b0001.
   - Same run without the macro → grant stays 4'b0001 and hold_cnt saturates at 255.

Source files
------------

// File: rtl/q2_rr_arbiter4.sv
// Four-requester round-robin arbiter: registered one-hot grant, mux select, busy and hold count.
// Optional owner preemption after MAX_HOLD cycles is enabled with `define ARB_HOLD_LIMIT_EN.
module q2_rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic [7:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nx;
  logic [1:0] last_ptr, last_ptr_nx;
  logic [1:0] sel_nx;
  logic [3:0] grant_nx;
  logic [7:0] hold_nx;
  logic       busy_nx;

  logic [3:0] cand;
  logic [1:0] search_ptr, start_idx, winner;
  logic [7:0] rot;
  logic       found;
  logic       others_pending;
  logic       preempt;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must lie in 2..255");
  end

  // Candidates exclude the current owner so a release or preemption always moves on.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cand       = req;
    search_ptr = last_ptr;
    if (state == GRANT) begin
      cand       = req & ~grant;
      search_ptr = sel;
    end
    start_idx = search_ptr + 2'd1;
    rot       = {cand, cand} >> start_idx;
    found     = 1'b0;
    winner    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) begin
        found  = 1'b1;
        winner = start_idx + 2'(i);
      end
    end
  end

  assign others_pending = |(req & ~grant);

`ifdef ARB_HOLD_LIMIT_EN
  assign preempt = (state == GRANT) && req[sel] && others_pending &&
                   (hold_cnt == 8'(MAX_HOLD - 1));
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    last_ptr_nx = last_ptr;
    sel_nx      = sel;
    grant_nx    = grant;
    hold_nx     = hold_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          grant_nx = 4'b0001 << winner;
          sel_nx   = winner;
          hold_nx  = 8'd0;
        end
      end
      GRANT: begin
        if (req[sel] && !preempt) begin
          if (hold_cnt != 8'hFF) hold_nx = hold_cnt + 8'd1;
        end else begin
          last_ptr_nx = sel;
          hold_nx     = 8'd0;
          if (found) begin
            grant_nx = 4'b0001 << winner;
            sel_nx   = winner;
          end else begin
            grant_nx = 4'b0000;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = |grant_nx;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state    <= IDLE;
      last_ptr <= 2'd3;
      sel      <= 2'd0;
      grant    <= 4'b0000;
      hold_cnt <= 8'd0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      last_ptr <= last_ptr_nx;
      sel      <= sel_nx;
      grant    <= grant_nx;
      hold_cnt <= hold_nx;
      busy     <= busy_nx;
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(grant));
  a_sel_matches   : assert property (@(posedge clk) disable iff (rst) busy |-> grant[sel]);

endmodule

// File: tb/tb_q2_rr_arbiter4.sv
// Self-checking bench for q2_rr_arbiter4: directed plan steps plus random traffic
// compared against an owner/pointer model built from the rotation rules.
module tb_q2_rr_arbiter4;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic [7:0] hold_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: owner index (-1 when nobody owns the mux).
  int m_owner = -1;
  int m_last  = 3;
  int m_hold  = 0;
  int m_sel   = 0;

  q2_rr_arbiter4 #(.MAX_HOLD(MAXH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .sel      (sel),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_update(input logic [3:0] r, input logic rr);
    logic [3:0] others;
    bit         preempt;
    if (rr) begin
      m_owner = -1; m_last = 3; m_hold = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      if (r != 4'b0000) begin
        m_owner = pick(r, m_last);
        m_sel   = m_owner;
        m_hold  = 0;
      end
    end else begin
      others  = r & ~(4'b0001 << m_owner);
      preempt = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      preempt = r[m_owner] && (m_hold == MAXH - 1) && (others != 4'b0000);
`endif
      if (r[m_owner] && !preempt) begin
        m_hold = (m_hold < 255) ? m_hold + 1 : 255;
      end else begin
        m_last = m_owner;
        m_hold = 0;
        if (others != 4'b0000) begin
          m_owner = pick(others, m_last);
          m_sel   = m_owner;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check("grant",    32'(grant),    32'(eg));
    check("sel",      32'(sel),      32'(m_sel));
    check("busy",     32'(busy),     32'(m_owner >= 0));
    check("hold_cnt", 32'(hold_cnt), 32'(m_hold));
  endtask

  task automatic step(input logic [3:0] r, input logic rr);
    req = r;
    rst = rr;
    @(posedge clk);
    model_update(r, rr);
    #1;
    check_model();
  endtask

  initial begin
    logic [3:0] exp_rot [4];
    logic [3:0] exp_g;
    logic [3:0] cur;
    exp_rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // 1. Reset with all requesting, then release.
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_sel",   32'(sel),   32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_hold",  32'(hold_cnt), 32'h0);
    step(4'b1111, 1'b0);
    check("first_grant", 32'(grant), 32'h1);
    check("first_sel",   32'(sel),   32'h0);
    step(4'b0000, 1'b0);

    // 2. Single requester held for five cycles.
    step(4'b0100, 1'b0);
    check("single_grant", 32'(grant), 32'h4);
    check("single_sel",   32'(sel),   32'h2);
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b0);
    check("single_hold4", 32'(hold_cnt), 32'h4);
    step(4'b0000, 1'b0);
    check("single_rel_grant", 32'(grant), 32'h0);
    check("single_rel_sel",   32'(sel),   32'h2);
    check("single_rel_busy",  32'(busy),  32'h0);

    // 3. Rotation: each owner drops its request after one owned cycle.
    step(4'b0000, 1'b1);
    step(4'b1111, 1'b0);
    check("rot_start", 32'(grant), 32'h1);
    cur = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(4'b1111 & ~cur, 1'b0);
      check("rot_seq",  32'(grant), 32'(exp_rot[i]));
      check("rot_busy", 32'(busy),  32'h1);
      cur = exp_rot[i];
    end

    // 4. Wrap: owner 3 released, then index 1 beats index 3.
    step(4'b1000, 1'b0);
    check("wrap_owner3", 32'(grant), 32'h8);
    step(4'b0000, 1'b0);
    step(4'b1010, 1'b0);
    check("wrap_prio", 32'(grant), 32'h2);

    // 5. Reset in the middle of a grant.
    step(4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b0100, 1'b0);
    check("mid_hold5", 32'(hold_cnt), 32'h5);
    step(4'b0100, 1'b1);
    check("mid_rst_grant", 32'(grant),    32'h0);
    check("mid_rst_hold",  32'(hold_cnt), 32'h0);
    step(4'b1110, 1'b0);
    check("mid_first", 32'(grant), 32'h2);

    // 6. Constant 4'b0011: preemption or saturation depending on the build.
    step(4'b0000, 1'b1);
    for (int k = 0; k < 270; k++) begin
      step(4'b0011, 1'b0);
`ifdef ARB_HOLD_LIMIT_EN
      exp_g = ((k / MAXH) % 2 == 0) ? 4'b0001 : 4'b0010;
      check("hold_grant", 32'(grant),    32'(exp_g));
      check("hold_cnt_k", 32'(hold_cnt), 32'(k % MAXH));
`else
      exp_g = 4'b0001;
      check("hold_grant", 32'(grant),    32'(exp_g));
      check("hold_cnt_k", 32'(hold_cnt), 32'((k < 255) ? k : 255));
`endif
    end

    // 7. Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(15, 0)), ($urandom_range(49, 0) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
